viterbi_traceback: RTL
======================

VITERBI_TRACEBACK -- requirements
Module: viterbi_traceback

Interface
REQ-001 SHALL have parameter word_num, default 16, the maximum sentence length in words.
REQ-002 SHALL have parameter word_num_bit, default 4, the width of a word index.
REQ-003 SHALL have parameter POS_num, default 11, the number of POS tags.
REQ-004 SHALL have parameter POS_num_bit, default 4, the width of a POS index.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: pulse that requests a traceback; sampled only in IDLE.
REQ-008 SHALL have port last_idx, input, word_num_bit: index of the final word (sentence length − 1); sampled with start.
REQ-009 SHALL have port last_pos, input, POS_num_bit: argmax POS of the final word; sampled with start.
REQ-010 SHALL have port bp_rd, output, 1 bit: backpointer-memory read strobe.
REQ-011 SHALL have port bp_addr, output, word_num_bit: word index of the read.
REQ-012 SHALL have port bp_pos, output, POS_num_bit: POS row of the read.
REQ-013 SHALL have port bp_data, input, POS_num_bit: predecessor POS, valid exactly 1 cycle after bp_rd.
REQ-014 SHALL have port tag_valid, output, 1 bit: tag output valid.
REQ-015 SHALL have port tag_ready, input, 1 bit: consumer accepts the tag.
REQ-016 SHALL have port tag_data, output, POS_num_bit: decoded POS.
REQ-017 SHALL have port tag_idx, output, word_num_bit: word index of tag_data.
REQ-018 SHALL have port tag_last, output, 1 bit: marks the final tag of the sentence.
REQ-019 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-020 SHALL have port done, output, 1 bit: one-cycle pulse after the last tag is accepted.
REQ-021 SHALL have port error, output, 1 bit: sticky flag for an illegal backpointer.

Function
REQ-022 SHALL implement the FSM states IDLE, RD, CAP, EMIT and DONE.
REQ-023 SHALL, in IDLE with start=1, push last_pos into a word_num×POS_num_bit LIFO, load idx=last_idx and cur=last_pos, and clear error.
REQ-024 SHALL, on leaving IDLE, go to EMIT if last_idx=0, else to RD.
REQ-025 SHALL, in RD, drive bp_rd=1, bp_addr=idx and bp_pos=cur for exactly one cycle, then go to CAP.
REQ-026 SHALL, in CAP with bp_data≥POS_num, set error=1, flush the LIFO and go to IDLE without emitting any tag.
REQ-027 SHALL, in CAP with a legal bp_data, push bp_data, set cur=bp_data and idx=idx−1, then go to EMIT if the new idx=0, else to RD.
REQ-028 SHALL spend 2 cycles per traced word; from start to first tag_valid takes 2*last_idx+1 cycles.
REQ-029 SHALL, in EMIT, drive tag_valid=1 with tag_data equal to the LIFO top and tag_idx counting 0,1,…,last_idx.
REQ-030 SHALL assert tag_last when a single LIFO entry remains.
REQ-031 SHALL hold tag_data, tag_idx and tag_last stable while tag_valid=1 and tag_ready=0.
REQ-032 SHALL pop the LIFO on a cycle with tag_valid & tag_ready, and go to DONE when the tag_last entry is popped.
REQ-033 SHALL pulse done=1 for one cycle in DONE, then go to IDLE.
REQ-034 SHALL ignore start while busy=1; start sampled in DONE is also ignored.
REQ-035 SHALL hold bp_rd low outside RD, and bp_addr/bp_pos at 0 when bp_rd=0.
REQ-036 SHALL keep the LIFO pointer within 0..word_num, with no wrap; a push never exceeds word_num entries because last_idx<word_num.

Reset
REQ-037 SHALL, on reset=0 at any time including mid-trace or mid-emit, immediately enter IDLE, empty the LIFO, and drive every output to 0 (tag_valid, tag_data, tag_idx, tag_last, bp_rd, bp_addr, bp_pos, busy, done, error).
REQ-038 SHALL resume operation on the first rising clk edge after reset returns to 1; LIFO contents need no reset, but the pointer SHALL be reset.

Structure
REQ-039 SHALL take word_num, word_num_bit, POS_num, POS_num_bit and the FSM state encoding from a shared viterbi package used by the datapath.
REQ-040 SHALL place the LIFO in one sub-module, pos_lifo (push, pop, top, count, empty), and keep the FSM in viterbi_traceback.

Verification
REQ-041 SHALL cover: last_idx=3, last_pos=2, memory bp[3][2]=5, bp[2][5]=0, bp[1][0]=7 → tags 7,0,5,2 with idx 0..3, tag_last on tag 2, first tag_valid 7 cycles after start.
REQ-042 SHALL cover: last_idx=0, last_pos=9 → no bp_rd; one tag 9 with idx 0 and tag_last=1; done one cycle after acceptance.
REQ-043 SHALL cover: REQ-041 memory with tag_ready toggling 1-0-0-1 → outputs stable during stalls and the same tag sequence.
REQ-044 SHALL cover: bp_data=12 on the first CAP → error=1, busy=0 the next cycle, no tag_valid; a following legal start clears error.
REQ-045 SHALL cover: reset=0 asserted while in EMIT after 2 of 4 tags → all outputs 0 asynchronously; a new start with last_idx=1 behaves normally.
REQ-046 SHALL cover: a start pulse while busy and last_idx=15 full-depth trace → the busy start is ignored; 16 tags, no overflow.

Source files
------------

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared sizes and FSM state encoding for the Viterbi traceback datapath
package viterbi_pkg;
   localparam int WORD_NUM     = 16;
   localparam int WORD_NUM_BIT = 4;
   localparam int POS_NUM      = 11;
   localparam int POS_NUM_BIT  = 4;
   typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_CAP, ST_EMIT, ST_DONE} state_t;
endpackage

// File: rtl/viterbi_traceback_lifo.sv
// pos_lifo: POS stack reversing the backward trace into forward tag order; ports clk/reset, i_flush/i_push/i_pop, i_din, o_top/o_count/o_empty
module pos_lifo
   import viterbi_pkg::*;
#(
   parameter int depth   = WORD_NUM,
   parameter int ptr_bit = WORD_NUM_BIT,
   parameter int width   = POS_NUM_BIT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_flush,
   input  logic               i_push,
   input  logic               i_pop,
   input  logic [width-1:0]   i_din,
   output logic [width-1:0]   o_top,
   output logic [ptr_bit:0]   o_count,
   output logic               o_empty
);
   logic [width-1:0] r_mem [depth];
   logic [ptr_bit:0] r_ptr;
   logic             w_full;
   logic [ptr_bit-1:0] w_top_addr;
   assign w_full     = r_ptr == (ptr_bit+1)'(depth);
   assign o_empty    = r_ptr == '0;
   assign o_count    = r_ptr;
   assign w_top_addr = r_ptr[ptr_bit-1:0] - 1'b1;
   assign o_top      = o_empty ? '0 : r_mem[w_top_addr];
   // Pointer saturates at both ends instead of wrapping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_ptr <= '0;
      else if (i_flush) r_ptr <= '0;
      else if (i_push && !w_full) r_ptr <= r_ptr + 1'b1;
      else if (i_pop && !o_empty) r_ptr <= r_ptr - 1'b1;
   end
   always_ff @(posedge clk) begin
      if (i_push && !w_full && !i_flush) r_mem[r_ptr[ptr_bit-1:0]] <= i_din;
   end
endmodule

// File: rtl/viterbi_traceback.sv
// viterbi_traceback: walks backpointers from the final word, then emits POS tags in forward order; ports start/last_idx/last_pos in, bp_rd/bp_addr/bp_pos/bp_data memory, tag_* stream out, busy/done/error status
module viterbi_traceback
   import viterbi_pkg::*;
#(
   parameter int word_num     = WORD_NUM,
   parameter int word_num_bit = WORD_NUM_BIT,
   parameter int POS_num      = POS_NUM,
   parameter int POS_num_bit  = POS_NUM_BIT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [word_num_bit-1:0] last_idx,
   input  logic [POS_num_bit-1:0]  last_pos,
   output logic                    bp_rd,
   output logic [word_num_bit-1:0] bp_addr,
   output logic [POS_num_bit-1:0]  bp_pos,
   input  logic [POS_num_bit-1:0]  bp_data,
   output logic                    tag_valid,
   input  logic                    tag_ready,
   output logic [POS_num_bit-1:0]  tag_data,
   output logic [word_num_bit-1:0] tag_idx,
   output logic                    tag_last,
   output logic                    busy,
   output logic                    done,
   output logic                    error
);
   state_t                  r_state, w_next;
   logic [word_num_bit-1:0] r_idx, w_idx_dec;
   logic [POS_num_bit-1:0]  r_cur, w_din, w_top;
   logic                    r_error;
   logic                    w_push, w_pop, w_flush, w_bad, w_empty, w_last;
   logic [word_num_bit:0]   w_count;
   pos_lifo #(.depth(word_num), .ptr_bit(word_num_bit), .width(POS_num_bit)) u_lifo (
      .clk     (clk),
      .reset   (reset),
      .i_flush (w_flush),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (w_din),
      .o_top   (w_top),
      .o_count (w_count),
      .o_empty (w_empty)
   );
   assign w_idx_dec = r_idx - 1'b1;
   assign w_bad     = {1'b0, bp_data} >= (POS_num_bit+1)'(POS_num);
   assign w_last    = w_count == (word_num_bit+1)'(1);
   always_comb begin
      w_next  = r_state;
      w_push  = 1'b0;
      w_pop   = 1'b0;
      w_flush = 1'b0;
      w_din   = last_pos;
      case (r_state)
         ST_IDLE: if (start) begin
            w_push = 1'b1;
            w_next = (last_idx == '0) ? ST_EMIT : ST_RD;
         end
         ST_RD:   w_next = ST_CAP;
         ST_CAP: if (w_bad) begin
            w_flush = 1'b1;
            w_next  = ST_IDLE;
         end else begin
            w_push = 1'b1;
            w_din  = bp_data;
            w_next = (w_idx_dec == '0) ? ST_EMIT : ST_RD;
         end
         ST_EMIT: if (tag_ready && !w_empty) begin
            w_pop  = 1'b1;
            w_next = w_last ? ST_DONE : ST_EMIT;
         end
         default: w_next = ST_IDLE;
      endcase
   end
   // r_idx counts down while tracing and reaches 0 on entry to EMIT, so it is reused as the forward tag index.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_cur   <= '0;
         r_error <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_IDLE && start) begin
            r_idx   <= last_idx;
            r_cur   <= last_pos;
            r_error <= 1'b0;
         end else if (r_state == ST_CAP) begin
            if (w_bad) r_error <= 1'b1;
            else begin
               r_idx <= w_idx_dec;
               r_cur <= bp_data;
            end
         end else if (w_pop && !w_last) r_idx <= r_idx + 1'b1;
      end
   end
   assign bp_rd     = r_state == ST_RD;
   assign bp_addr   = bp_rd ? r_idx : '0;
   assign bp_pos    = bp_rd ? r_cur : '0;
   assign tag_valid = r_state == ST_EMIT && !w_empty;
   assign tag_data  = tag_valid ? w_top : '0;
   assign tag_idx   = tag_valid ? r_idx : '0;
   assign tag_last  = tag_valid && w_last;
   assign busy      = r_state != ST_IDLE;
   assign done      = r_state == ST_DONE;
   assign error     = r_error;
endmodule
